fir_seq_ctrl: RTL and testbench
===============================

Name: fir_seq_ctrl

Overview:
Command/status sequencer between the AXI-Lite slave register wrapper and the FIR datapath. Decodes host register writes and latches the run configuration. Gates the input sample stream for exactly the programmed number of samples, then counts output samples until the datapath drains. Publishes busy/done/error status and counters back through the register read path, and raises a done interrupt pulse.

Parameters:
DATA_WIDTH, 64, register width; matches the AXI-Lite data width.
NUM_REGISTER, 7, number of host registers; register NUM_REGISTER-1 is the command/status register.
MAX_TAPS, 32, largest legal tap count.
CNT_WIDTH, 32, width of the sample counters.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous active-low
slv_reg_down  input  NUM_REGISTER*DATA_WIDTH  host-written register image; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
slv_reg_up  output  NUM_REGISTER*DATA_WIDTH  register read-back image
access_addr  input  $clog2(NUM_REGISTER)  register index of the current host access
write_valid  input  1  one-cycle pulse; host wrote register access_addr
read_valid  input  1  one-cycle pulse; host read register access_addr
cfg_num_taps  output  $clog2(MAX_TAPS)+1  latched tap count to the datapath
dp_start  output  1  one-cycle pulse on run start
dp_flush  output  1  one-cycle pulse on abort
up_valid  input  1  upstream sample valid
up_ready  output  1  upstream sample ready
dp_in_valid  output  1  sample valid into the datapath
dp_in_ready  input  1  datapath ready
dp_out_valid  input  1  datapath output valid
dp_out_ready  input  1  downstream ready (monitored only)
irq  output  1  one-cycle done interrupt

Behaviour:
- Register map:
  - reg0[CNT_WIDTH-1:0] = num_samples.
  - reg1[7:0] = num_taps.
  - reg2..reg(N-2) = pass-through.
  - CMD = reg(N-1):
    - write bit0 = START, bit1 = ABORT.
    - read returns {out_cnt[31:0] in [63:32], err_busy bit3, err_cfg bit2, done bit1, busy bit0}.
- slv_reg_up: regs 0..N-2 echo slv_reg_down combinationally; CMD slot holds the status word.
- Reset: state IDLE; all counters 0; busy, done, err_cfg, err_busy, dp_start, dp_flush, irq = 0; cfg_num_taps = 0; up_ready and dp_in_valid = 0.
- Command decode happens only when write_valid=1 and access_addr=N-1. Writes to other registers have no effect on the FSM.
- FSM IDLE:
  - START with num_samples=0, num_taps=0 or num_taps>MAX_TAPS: set err_cfg, stay IDLE.
  - Otherwise, on the next edge:
    - latch the config;
    - clear in_cnt, out_cnt, done and both error bits;
    - pulse dp_start;
    - go to RUN.
- FSM RUN:
  - dp_in_valid = up_valid; up_ready = dp_in_ready. Both are combinational and active only in RUN.
  - in_cnt increments on each up_valid&dp_in_ready.
  - When the accepted sample makes in_cnt reach num_samples, go to DRAIN on that same edge. From that cycle on, up_ready=0 (never over-accept).
- Output counting: in RUN and DRAIN, out_cnt increments on dp_out_valid&dp_out_ready. Output handshakes in RUN are counted.
- FSM DRAIN: when out_cnt reaches num_samples, go to DONE.
- FSM DONE (one cycle): set done (sticky), pulse irq, return to IDLE.
- busy = 1 in RUN and DRAIN.
- ABORT in RUN or DRAIN:
  - pulse dp_flush;
  - go to IDLE without setting done;
  - counters hold their last value.
  - ABORT in IDLE is ignored.
- START in RUN or DRAIN: ignored; sets err_busy.
- START and ABORT in the same write: ABORT wins when busy; START wins when idle.
- A read of CMD (read_valid, access_addr=N-1) clears done on the next edge. If done is being set in the same cycle, set wins.
- Latency:
  - START write at cycle n → busy=1 and up_ready may assert at n+1.
  - Last output handshake at cycle m → done=1 and irq at m+2.
- Counters saturate at all-ones and never wrap.
- Asynchronous reset mid-run returns everything to reset values immediately; no flush pulse is issued.

Test Plan:
- Nominal run: num_samples=8, taps=4, START; feed 8 samples then 8 outputs → exactly 8 up_ready handshakes; busy drops; done=1; irq is a single pulse; CMD read gives out_cnt=8, bits=0x2.
- Back-pressure: same run with dp_in_ready toggling 1/0 and a 9th sample held valid → 9th sample never accepted; in_cnt=8; up_ready=0 in DRAIN.
- Bad config: taps=0, then taps=33, then samples=0, each followed by START → err_cfg=1, busy stays 0, dp_start never pulses.
- Abort: START with 100 samples; ABORT after 10 inputs → dp_flush one pulse; state IDLE; done=0; in_cnt=10.
- START while busy → err_busy=1 and the run completes normally. Then read CMD in the same cycle done is set → done stays 1; a second read clears it.
- Reset mid-DRAIN (rst_n low for 1 cycle) → all outputs go to reset values asynchronously; no irq is issued.

Source files
------------

// File: rtl/fir_seq_ctrl.sv
// Run sequencer between the AXI-Lite register wrapper and the FIR datapath:
// decodes CMD writes, meters input samples, counts outputs, publishes status.
module fir_seq_ctrl #(
  parameter int DATA_WIDTH   = 64,
  parameter int NUM_REGISTER = 7,
  parameter int MAX_TAPS     = 32,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REGISTER*DATA_WIDTH-1:0] slv_reg_down,
  output logic [NUM_REGISTER*DATA_WIDTH-1:0] slv_reg_up,
  input  logic [$clog2(NUM_REGISTER)-1:0]    access_addr,
  input  logic                               write_valid,
  input  logic                               read_valid,
  output logic [$clog2(MAX_TAPS):0]          cfg_num_taps,
  output logic                               dp_start,
  output logic                               dp_flush,
  input  logic                               up_valid,
  output logic                               up_ready,
  output logic                               dp_in_valid,
  input  logic                               dp_in_ready,
  input  logic                               dp_out_valid,
  input  logic                               dp_out_ready,
  output logic                               irq
);
  localparam int AW  = $clog2(NUM_REGISTER);
  localparam int TW  = $clog2(MAX_TAPS) + 1;
  localparam int CMD = NUM_REGISTER - 1;
  localparam logic [AW-1:0] CMD_ADDR = AW'(CMD);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] ns_q, ns_d;
  logic [CNT_WIDTH-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic [TW-1:0]        taps_q, taps_d;
  logic done_q, done_d, err_cfg_q, err_cfg_d, err_busy_q, err_busy_d;
  logic dp_start_q, dp_start_d, dp_flush_q, dp_flush_d, irq_q, irq_d;

  logic [DATA_WIDTH-1:0] cmd_w, status_w;
  logic [CNT_WIDTH-1:0]  num_samples;
  logic [7:0]            num_taps;
  logic cmd_wr, cmd_rd, req_start, req_abort, cfg_bad, busy, in_hs, out_hs;
  logic unused_cmd;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  assign cmd_w       = slv_reg_down[CMD*DATA_WIDTH +: DATA_WIDTH];
  assign num_samples = slv_reg_down[CNT_WIDTH-1:0];
  assign num_taps    = slv_reg_down[DATA_WIDTH +: 8];
  assign cmd_wr      = write_valid && (access_addr == CMD_ADDR);
  assign cmd_rd      = read_valid && (access_addr == CMD_ADDR);
  assign req_start   = cmd_wr && cmd_w[0];
  assign req_abort   = cmd_wr && cmd_w[1];
  assign cfg_bad     = (num_samples == '0) || (num_taps == 8'd0) || (num_taps > 8'(MAX_TAPS));
  assign unused_cmd  = ^cmd_w[DATA_WIDTH-1:2];

  assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign dp_in_valid = (state_q == S_RUN) && up_valid;
  assign up_ready    = (state_q == S_RUN) && dp_in_ready;
  assign in_hs       = (state_q == S_RUN) && up_valid && dp_in_ready;
  assign out_hs      = busy && dp_out_valid && dp_out_ready;

  always_comb begin
    state_d    = state_q;
    ns_d       = ns_q;
    taps_d     = taps_q;
    in_cnt_d   = in_hs ? sat_inc(in_cnt_q) : in_cnt_q;
    out_cnt_d  = out_hs ? sat_inc(out_cnt_q) : out_cnt_q;
    done_d     = cmd_rd ? 1'b0 : done_q;
    err_cfg_d  = err_cfg_q;
    err_busy_d = err_busy_q;
    dp_start_d = 1'b0;
    dp_flush_d = 1'b0;
    irq_d      = 1'b0;
    case (state_q)
      S_IDLE: if (req_start) begin
        if (cfg_bad) begin
          err_cfg_d = 1'b1;
        end else begin
          ns_d       = num_samples;
          taps_d     = num_taps[TW-1:0];
          in_cnt_d   = '0;
          out_cnt_d  = '0;
          done_d     = 1'b0;
          err_cfg_d  = 1'b0;
          err_busy_d = 1'b0;
          dp_start_d = 1'b1;
          state_d    = S_RUN;
        end
      end
      S_RUN, S_DRAIN: begin
        // ABORT takes priority over a simultaneous START while busy
        if (req_abort) begin
          dp_flush_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          if (req_start) err_busy_d = 1'b1;
          if (state_q == S_RUN && in_hs && sat_inc(in_cnt_q) == ns_q)
            state_d = S_DRAIN;
          // setting done here lands it two cycles after the last output beat
          if (state_q == S_DRAIN && out_cnt_q >= ns_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            irq_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ns_q       <= '0;
      taps_q     <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      done_q     <= 1'b0;
      err_cfg_q  <= 1'b0;
      err_busy_q <= 1'b0;
      dp_start_q <= 1'b0;
      dp_flush_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ns_q       <= ns_d;
      taps_q     <= taps_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      done_q     <= done_d;
      err_cfg_q  <= err_cfg_d;
      err_busy_q <= err_busy_d;
      dp_start_q <= dp_start_d;
      dp_flush_q <= dp_flush_d;
      irq_q      <= irq_d;
    end
  end

  assign cfg_num_taps = taps_q;
  assign dp_start     = dp_start_q;
  assign dp_flush     = dp_flush_q;
  assign irq          = irq_q;

  always_comb begin
    status_w        = '0;
    status_w[3:0]   = {err_busy_q, err_cfg_q, done_q, busy};
    status_w[63:32] = 32'(out_cnt_q);
  end

  genvar gi;
  generate
    for (gi = 0; gi < CMD; gi++) begin : g_echo
      assign slv_reg_up[gi*DATA_WIDTH +: DATA_WIDTH] = slv_reg_down[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate
  assign slv_reg_up[CMD*DATA_WIDTH +: DATA_WIDTH] = status_w;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl: cycle table for a short run plus
// hand sequences for back-pressure, bad config, abort, busy start, reset.
module tb_fir_seq_ctrl;
  localparam int DW = 64;
  localparam int NR = 7;
  localparam int AW = $clog2(NR);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR*DW-1:0] slv_reg_down = '0;
  logic [NR*DW-1:0] slv_reg_up;
  logic [AW-1:0]    access_addr = '0;
  logic             write_valid = 1'b0, read_valid = 1'b0;
  logic [5:0]       cfg_num_taps;
  logic             dp_start, dp_flush, irq;
  logic             up_valid = 1'b0, up_ready, dp_in_valid, dp_in_ready = 1'b0;
  logic             dp_out_valid = 1'b0, dp_out_ready = 1'b1;

  fir_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .slv_reg_down(slv_reg_down), .slv_reg_up(slv_reg_up),
    .access_addr(access_addr), .write_valid(write_valid), .read_valid(read_valid),
    .cfg_num_taps(cfg_num_taps), .dp_start(dp_start), .dp_flush(dp_flush),
    .up_valid(up_valid), .up_ready(up_ready), .dp_in_valid(dp_in_valid),
    .dp_in_ready(dp_in_ready), .dp_out_valid(dp_out_valid),
    .dp_out_ready(dp_out_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // in  = {write_valid, read_valid, up_valid, dp_in_ready, dp_out_valid}
  // exp = {busy, up_ready, dp_in_valid, dp_start, irq, done}
  typedef struct {
    logic [4:0] in;
    logic [5:0] exp;
    logic [7:0] ocnt;
  } vec_t;
  vec_t vec [9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] stat();
    return slv_reg_up[6*DW +: DW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reg(input int i, input logic [63:0] v);
    slv_reg_down[i*DW +: DW] = v;
  endtask

  task automatic wr_cmd(input logic [63:0] v);
    set_reg(6, v);
    access_addr = 3'd6;
    write_valid = 1'b1;
    step();
    write_valid = 1'b0;
  endtask

  task automatic run_start(input logic [63:0] ns, input logic [63:0] taps);
    set_reg(0, ns);
    set_reg(1, taps);
    wr_cmd(64'h1);
  endtask

  initial begin
    int hs, irqn, stn, fln;
    vec[0] = '{5'b10000, 6'b000000, 8'd0};
    vec[1] = '{5'b00110, 6'b111100, 8'd0};
    vec[2] = '{5'b00110, 6'b111000, 8'd0};
    vec[3] = '{5'b00111, 6'b100000, 8'd0};
    vec[4] = '{5'b00011, 6'b100000, 8'd1};
    vec[5] = '{5'b00000, 6'b100000, 8'd2};
    vec[6] = '{5'b00000, 6'b000011, 8'd2};
    vec[7] = '{5'b01000, 6'b000001, 8'd2};
    vec[8] = '{5'b00000, 6'b000000, 8'd2};

    // reset state
    #12;
    chk("rst_busy", {63'd0, stat()[0]}, 64'd0);
    chk("rst_status", stat(), 64'd0);
    chk("rst_outs", {58'd0, up_ready, dp_in_valid, dp_start, dp_flush, irq, 1'b0}, 64'd0);
    chk("rst_taps", {58'd0, cfg_num_taps}, 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();

    // cycle table: 2-sample run, 4 taps
    set_reg(0, 64'd2);
    set_reg(1, 64'd4);
    set_reg(6, 64'h1);
    access_addr = 3'd6;
    for (int r = 0; r < 9; r++) begin
      {write_valid, read_valid, up_valid, dp_in_ready, dp_out_valid} = vec[r].in;
      #1;
      chk($sformatf("tbl%0d_busy", r),  {63'd0, stat()[0]},  {63'd0, vec[r].exp[5]});
      chk($sformatf("tbl%0d_urdy", r),  {63'd0, up_ready},   {63'd0, vec[r].exp[4]});
      chk($sformatf("tbl%0d_dinv", r),  {63'd0, dp_in_valid}, {63'd0, vec[r].exp[3]});
      chk($sformatf("tbl%0d_start", r), {63'd0, dp_start},   {63'd0, vec[r].exp[2]});
      chk($sformatf("tbl%0d_irq", r),   {63'd0, irq},        {63'd0, vec[r].exp[1]});
      chk($sformatf("tbl%0d_done", r),  {63'd0, stat()[1]},  {63'd0, vec[r].exp[0]});
      chk($sformatf("tbl%0d_ocnt", r),  {32'd0, stat()[63:32]}, {56'd0, vec[r].ocnt});
      @(posedge clk);
      #1;
    end
    {write_valid, read_valid, up_valid, dp_in_ready, dp_out_valid} = 5'b0;
    chk("tbl_taps", {58'd0, cfg_num_taps}, 64'd4);

    // 8-sample run with toggling dp_in_ready and upstream always valid
    run_start(64'd8, 64'd4);
    chk("bp_start", {63'd0, dp_start}, 64'd1);
    up_valid = 1'b1;
    hs = 0;
    for (int c = 0; c < 30; c++) begin
      dp_in_ready = (c % 2 == 0);
      #1;
      if (up_valid && up_ready) hs++;
      step();
    end
    dp_in_ready = 1'b1;
    #1;
    chk("bp_in_hs", hs, 8);
    chk("bp_drain_urdy", {63'd0, up_ready}, 64'd0);
    chk("bp_drain_busy", {63'd0, stat()[0]}, 64'd1);
    up_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dp_out_valid = 1'b1;
      step();
    end
    dp_out_valid = 1'b0;
    irqn = 0;
    for (int c = 0; c < 10; c++) begin
      if (irq) irqn++;
      step();
    end
    chk("bp_irq_pulses", irqn, 1);
    chk("bp_status", stat(), {32'd8, 32'h2});

    // invalid configurations: taps=0, taps=33, samples=0
    chk("cfg_err_clear", {63'd0, stat()[2]}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      stn = 0;
      run_start((k == 2) ? 64'd0 : 64'd8, (k == 0) ? 64'd0 : (k == 1) ? 64'd33 : 64'd4);
      if (dp_start) stn++;
      step();
      if (dp_start) stn++;
      chk($sformatf("cfg%0d_err", k), {63'd0, stat()[2]}, 64'd1);
      chk($sformatf("cfg%0d_busy", k), {63'd0, stat()[0]}, 64'd0);
      chk($sformatf("cfg%0d_start", k), stn, 0);
    end

    // abort after 10 inputs, 3 outputs counted during RUN
    run_start(64'd100, 64'd4);
    chk("ab_cfg_err_cleared", {63'd0, stat()[2]}, 64'd0);
    hs = 0;
    for (int i = 0; i < 10; i++) begin
      up_valid = 1'b1;
      dp_in_ready = 1'b1;
      dp_out_valid = (i < 3);
      #1;
      if (up_ready) hs++;
      step();
    end
    up_valid = 1'b0;
    dp_out_valid = 1'b0;
    wr_cmd(64'h2);
    chk("ab_flush", {63'd0, dp_flush}, 64'd1);
    chk("ab_status", stat(), {32'd3, 32'h0});
    chk("ab_in_hs", hs, 10);
    dp_out_valid = 1'b1;
    step();
    step();
    dp_out_valid = 1'b0;
    chk("ab_flush_pulse", {63'd0, dp_flush}, 64'd0);
    chk("ab_ocnt_hold", {32'd0, stat()[63:32]}, 64'd3);
    wr_cmd(64'h2);
    chk("ab_idle_ignored", {62'd0, dp_flush, stat()[0]}, 64'd0);

    // START+ABORT: start wins in IDLE, abort wins when busy
    wr_cmd(64'h3);
    chk("sa_idle_start", {62'd0, dp_start, stat()[0]}, 64'd3);
    wr_cmd(64'h3);
    chk("sa_busy_abort", {60'd0, stat()[3], dp_flush, stat()[0], dp_start}, 64'b0100);

    // START while busy, then CMD read coincident with done being set
    run_start(64'd2, 64'd4);
    up_valid = 1'b1;
    dp_in_ready = 1'b1;
    wr_cmd(64'h1);
    chk("eb_err_busy", {62'd0, stat()[3], stat()[0]}, 64'b11);
    step();
    up_valid = 1'b0;
    dp_out_valid = 1'b1;
    step();
    step();
    dp_out_valid = 1'b0;
    read_valid = 1'b1;
    access_addr = 3'd6;
    #1;
    chk("eb_done_pre", {62'd0, stat()[1], irq}, 64'd0);
    step();
    read_valid = 1'b0;
    chk("eb_done_set_wins", {62'd0, stat()[1], irq}, 64'b11);
    step();
    chk("eb_done_sticky", stat(), {32'd2, 32'hA});
    read_valid = 1'b1;
    step();
    read_valid = 1'b0;
    chk("eb_done_cleared", {63'd0, stat()[1]}, 64'd0);

    // asynchronous reset while draining
    run_start(64'd4, 64'd4);
    up_valid = 1'b1;
    dp_in_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    up_valid = 1'b0;
    chk("rs_drain_busy", {62'd0, stat()[0], up_ready}, 64'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_status", stat(), 64'd0);
    chk("rs_outs", {58'd0, up_ready, dp_in_valid, dp_start, dp_flush, irq, 1'b0}, 64'd0);
    chk("rs_taps", {58'd0, cfg_num_taps}, 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    irqn = 0;
    fln = 0;
    dp_out_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (irq) irqn++;
      if (dp_flush) fln++;
    end
    dp_out_valid = 1'b0;
    chk("rs_no_irq", irqn, 0);
    chk("rs_no_flush", fln, 0);
    chk("rs_idle_ocnt", stat(), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
